// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, drives a one-cycle synchronous ROM and queues returned words for decode.
// Optional feature: define IF_HALT_ON_ZERO_EN to stop fetching when an all-zero terminator word returns.
module instr_fetch_ctrl #(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_instr,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [ADDR_W-1:0] if_pc,
    output logic [31:0]       if_instr,
    output logic              halted
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] inflight_pc_q;
    logic              inflight_q;

    logic [ADDR_W-1:0] pc_mem    [FIFO_DEPTH];
    logic [31:0]       instr_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [CNT_W-1:0]  count_q;

    logic              pop;
    logic              push;
    logic              issue;
    logic              zero_hit;
    logic [CNT_W:0]    occupancy;

    assign imem_addr = pc_q;
    assign if_valid  = (count_q != '0);
    assign pop       = if_valid & if_ready;

`ifdef IF_HALT_ON_ZERO_EN
    logic halted_q;
    assign zero_hit = inflight_q & (imem_instr == 32'h0);
    assign halted   = halted_q;
`else
    assign zero_hit = 1'b0;
    assign halted   = 1'b0;
`endif

    // A terminator word is consumed here and never reaches the buffer.
    assign push = inflight_q & ~redirect_valid & ~zero_hit;

    // Slots already spoken for: queued words plus the word on its way back, minus the one leaving now.
    assign occupancy = {1'b0, count_q}
                     + {{CNT_W{1'b0}}, inflight_q}
                     - {{CNT_W{1'b0}}, pop};

    assign issue = (state_q == RUN) & ~redirect_valid & ~zero_hit & (occupancy < DEPTH_C);

    assign if_pc    = if_valid ? pc_mem[rd_ptr_q]    : '0;
    assign if_instr = if_valid ? instr_mem[rd_ptr_q] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            inflight_pc_q <= '0;
            inflight_q    <= 1'b0;
            state_q       <= RUN;
`ifdef IF_HALT_ON_ZERO_EN
            halted_q      <= 1'b0;
`endif
        end else if (redirect_valid) begin
            // Dropping inflight_q discards the stale word that returns next cycle.
            pc_q       <= redirect_pc;
            inflight_q <= 1'b0;
            state_q    <= RUN;
`ifdef IF_HALT_ON_ZERO_EN
            halted_q   <= 1'b0;
`endif
        end else begin
            inflight_q <= issue;
            if (issue) begin
                pc_q          <= pc_q + ADDR_W'(1);
                inflight_pc_q <= pc_q;
            end
`ifdef IF_HALT_ON_ZERO_EN
            if (zero_hit) begin
                state_q  <= HALT;
                halted_q <= 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (redirect_valid) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; outputs are gated by if_valid, so old contents are never seen.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]    <= inflight_pc_q;
            instr_mem[wr_ptr_q] <= imem_instr;
        end
    end

endmodule
